// File: rtl/instr_issue_tx.sv
// Transmitter side of the four-phase req/ack link from fetch to decode.
// Buffers fetched instruction/PC words and issues each one as a
// return-to-zero handshake. The ack is synchronised, a branch flush drops
// words that have not been launched, and a stalled handshake is flagged.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   in_valid/in_ready    fetch-side valid/ready (in_ready = count < DEPTH)
//   in_instr, in_pc      word written into the buffer
//   flush                discard every buffered (unlaunched) word
//   req, ack             four-phase handshake towards decode
//   instr_out, pc_out    word presented with req, held between launches
//   busy                 transaction in flight
//   err_timeout          sticky: no ack edge within TIMEOUT cycles
//   tx_count             completed transactions (wrapping)
module instr_issue_tx #(
   parameter int unsigned DEPTH       = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] in_instr,
   input  logic [7:0]  in_pc,
   output logic        in_ready,
   input  logic        flush,
   output logic        req,
   input  logic        ack,
   output logic [31:0] instr_out,
   output logic [7:0]  pc_out,
   output logic        busy,
   output logic        err_timeout,
   output logic [15:0] tx_count
);

   localparam int unsigned IW       = 32;
   localparam int unsigned PCW      = 8;
   localparam int unsigned TXW      = 16;
   localparam int unsigned AW       = $clog2(DEPTH);
   localparam int unsigned PW       = AW + 1;
   localparam int unsigned CW       = $clog2(TIMEOUT + 2);
   localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t            state;
   state_t            next_state;
   logic              launch;
   logic              tx_done;

   logic [IW-1:0]     mem_instr [DEPTH];
   logic [PCW-1:0]    mem_pc    [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     count;
   logic              empty;
   logic              wr_en;

   logic [SYNC_STAGES-1:0] sync_q;
   logic              ack_s;

   logic [CW-1:0]     tmo_cnt;
   logic              state_chg;

   // Buffer occupancy from the extra-bit pointers
   assign count    = wr_ptr - rd_ptr;
   assign empty    = (count == '0);
   assign in_ready = (count < PW'(DEPTH));
   // A word offered in the same cycle as a flush is dropped with the rest
   assign wr_en    = in_valid && in_ready && !flush;

   // Ack synchroniser; all FSM decisions use ack_s only
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ack};
      end
   end
   assign ack_s = sync_q[SYNC_STAGES-1];

   // Buffer storage (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_instr[wr_ptr[AW-1:0]] <= in_instr;
         mem_pc[wr_ptr[AW-1:0]]    <= in_pc;
      end
   end

   // Buffer pointers; flush empties the buffer by catching rd up to wr
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
      end else begin
         if (wr_en)  wr_ptr <= wr_ptr + PW'(1);
         if (launch) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state; a stale ack_s=1 in IDLE holds off the launch
   always_comb begin
      next_state = state;
      launch     = 1'b0;
      tx_done    = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && !ack_s && !flush) begin
               launch     = 1'b1;
               next_state = REQ;
            end
         end
         REQ: begin
            if (ack_s) begin
               tx_done    = 1'b1;
               next_state = RELEASE;
            end
         end
         RELEASE: begin
            if (!ack_s) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Registered handshake outputs; data only moves on a launch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req       <= 1'b0;
         busy      <= 1'b0;
         instr_out <= '0;
         pc_out    <= '0;
         tx_count  <= '0;
      end else begin
         req  <= (next_state == REQ);
         busy <= (next_state != IDLE);
         if (launch) begin
            instr_out <= mem_instr[rd_ptr[AW-1:0]];
            pc_out    <= mem_pc[rd_ptr[AW-1:0]];
         end
         if (tx_done) tx_count <= tx_count + TXW'(1);
      end
   end

   assign state_chg = (next_state != state);

   // Handshake stall watchdog: counts cycles spent in the current phase
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt     <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (state_chg) begin
            tmo_cnt <= '0;
         end else if (state != IDLE && tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + CW'(1);
         end
         if (TIMEOUT != 0 && state != IDLE && !state_chg &&
             tmo_cnt == CW'(TMO_LAST)) begin
            err_timeout <= 1'b1;
         end
      end
   end

endmodule
